// File: rtl/bcd_updown_counter.sv
// BCD modulo-N up/down digit counter for the clock datapath.
// Counts by cascade carry-in or by the up/down set buttons (with auto-repeat),
// accepts a synchronous preset, and emits a one-cycle carry on cascade wrap.
// o_state exposes the button/repeat FSM (0=IDLE, 1=DELAY, 2=REPEAT).
//
// Input handshake: there is no valid/ready here. i_ena is a one-cycle tick
// strobe; i_cin, i_up and i_down are sampled only on ticks, while i_load is
// sampled on every clock edge and overrides everything else.
module bcd_updown_counter #(
    parameter int MODULUS      = 60,
    parameter int DIGITS       = 2,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_ena,
    input  logic                  i_cin,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_val,
    output logic [4*DIGITS-1:0]   o_q,
    output logic                  o_carry,
    output logic [1:0]            o_state
);

    localparam int W    = 4 * DIGITS;
    localparam int MAXT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(MAXT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Binary to BCD, used to form the top count value at elaboration time.
    function automatic logic [W-1:0] bin_to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = bin_to_bcd(MODULUS - 1);

    // BCD increment with digit ripple; the modulus wrap is handled by the caller.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (c) begin
                if (r[4*d +: 4] >= 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD decrement with digit borrow; the modulus wrap is handled by the caller.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (b) begin
                if (r[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A preset is accepted only if every nibble is a decimal digit and the
    // value lies inside the counting range.
    function automatic logic load_valid(input logic [W-1:0] v);
        int   acc;
        logic ok;
        acc = 0;
        ok  = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (v[4*d +: 4] > 4'd9) ok = 1'b0;
            acc = acc * 10 + int'(v[4*d +: 4]);
        end
        return ok && (acc < MODULUS);
    endfunction

    state_t         state;
    state_t         state_nxt;
    logic           dir_down;
    logic           dir_nxt;
    logic [CW-1:0]  tick_cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [CW-1:0]  cnt_inc;
    logic           one_btn;
    logic           btn_step;
    logic           btn_down;
    logic           casc_step;
    logic           step_down;
    logic           wrap_carry;
    logic [W-1:0]   q_up;
    logic [W-1:0]   q_dn;
    logic [W-1:0]   q_next;

    assign o_state = state;
    assign cnt_inc = tick_cnt + 1'b1;
    assign one_btn = i_up ^ i_down;

    // Button/repeat FSM next state plus the step decision for the coming tick.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_down;
        cnt_nxt   = tick_cnt;
        btn_step  = 1'b0;
        btn_down  = 1'b0;
        if (!one_btn) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    btn_step  = 1'b1;
                    btn_down  = i_down;
                    dir_nxt   = i_down;
                    cnt_nxt   = '0;
                    state_nxt = ST_DELAY;
                end
                ST_DELAY: begin
                    if (i_down != dir_down) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == CW'(REPEAT_DELAY)) begin
                        btn_step  = 1'b1;
                        btn_down  = dir_down;
                        cnt_nxt   = '0;
                        state_nxt = ST_REPEAT;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_REPEAT: begin
                    if (i_down != dir_down) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == CW'(REPEAT_RATE)) begin
                        btn_step = 1'b1;
                        btn_down = dir_down;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Cascade steps only when the buttons did not claim this tick.
    always_comb begin
        casc_step  = i_cin && !btn_step;
        step_down  = btn_step && btn_down;
        q_up       = (o_q == MAX_BCD) ? '0 : bcd_inc(o_q);
        q_dn       = (o_q == '0) ? MAX_BCD : bcd_dec(o_q);
        q_next     = step_down ? q_dn : q_up;
        wrap_carry = casc_step && (o_q == MAX_BCD);
    end

    // Count register, FSM state and registered carry; load beats tick.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_q      <= '0;
            o_carry  <= 1'b0;
            state    <= ST_IDLE;
            dir_down <= 1'b0;
            tick_cnt <= '0;
        end else if (i_load) begin
            o_q      <= load_valid(i_load_val) ? i_load_val : '0;
            o_carry  <= 1'b0;
            state    <= ST_IDLE;
            tick_cnt <= '0;
        end else if (i_ena) begin
            state    <= state_nxt;
            dir_down <= dir_nxt;
            tick_cnt <= cnt_nxt;
            if (btn_step || casc_step) begin
                o_q <= q_next;
            end
            o_carry <= wrap_carry;
        end else begin
            o_carry <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: default 60-modulus instance plus a
// 24-modulus instance sharing the same stimulus.
module tb_bcd_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       cin;
    logic       up;
    logic       down;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q1;
    logic       carry1;
    logic [1:0] st1;
    logic [7:0] q2;
    logic       carry2;
    logic [1:0] st2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       ena;
        logic       cin;
        logic       up;
        logic       down;
        logic       load;
        logic [7:0] val;
        logic [7:0] exp_q;
        logic       exp_c;
        logic [1:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_updown_counter dut1 (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_ena      (ena),
        .i_cin      (cin),
        .i_up       (up),
        .i_down     (down),
        .i_load     (load),
        .i_load_val (load_val),
        .o_q        (q1),
        .o_carry    (carry1),
        .o_state    (st1)
    );

    bcd_updown_counter #(.MODULUS(24)) dut2 (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_ena      (ena),
        .i_cin      (cin),
        .i_up       (up),
        .i_down     (down),
        .i_load     (load),
        .i_load_val (load_val),
        .o_q        (q2),
        .o_carry    (carry2),
        .o_state    (st2)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic e, input logic c, input logic u,
                         input logic d, input logic l, input logic [7:0] v);
        ena      = e;
        cin      = c;
        up       = u;
        down     = d;
        load     = l;
        load_val = v;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic c, input logic u, input logic d,
                       input logic l, input logic [7:0] v, input logic [7:0] q,
                       input logic cy, input logic [1:0] s);
        vec_t t;
        t.ena = e; t.cin = c; t.up = u; t.down = d; t.load = l; t.val = v;
        t.exp_q = q; t.exp_c = cy; t.exp_st = s;
        vecs.push_back(t);
    endtask

    initial begin
        logic seen;
        int   steps;

        rst_n = 1'b1;
        ena = 0; cin = 0; up = 0; down = 0; load = 0; load_val = 8'h00;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("reset_q", int'(q1), 'h00);
        chk("reset_carry", int'(carry1), 0);
        chk("reset_state", int'(st1), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Cascade count through the full modulus
        seen = 1'b0;
        for (int i = 0; i < 59; i++) begin
            drive(1, 1, 0, 0, 0, 8'h00);
            if (carry1) seen = 1'b1;
        end
        chk("casc_59_q", int'(q1), 'h59);
        chk("casc_59_nocarry", int'(seen), 0);
        drive(1, 1, 0, 0, 0, 8'h00);
        chk("casc_wrap_q", int'(q1), 'h00);
        chk("casc_wrap_carry", int'(carry1), 1);
        drive(0, 0, 0, 0, 0, 8'h00);
        chk("casc_carry_drop", int'(carry1), 0);

        // Held up button: steps on ticks 1, 9, 11, 13, 15
        steps = 0;
        seen  = 1'b0;
        for (int t = 1; t <= 15; t++) begin
            drive(1, 0, 1, 0, 0, 8'h00);
            if (t == 1 || t == 9 || (t >= 11 && (t % 2) == 1)) steps++;
            chk($sformatf("hold_up_t%0d", t), int'(q1), steps);
            if (carry1) seen = 1'b1;
        end
        chk("hold_up_nocarry", int'(seen), 0);
        chk("hold_up_state", int'(st1), 2);
        drive(1, 0, 0, 0, 0, 8'h00);
        chk("release_q", int'(q1), 'h05);
        chk("release_state", int'(st1), 0);

        // Table: ena cin up down load val | q carry state
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        add(1, 0, 0, 1, 0, 8'h00, 8'h59, 0, 1);
        add(1, 0, 0, 0, 0, 8'h00, 8'h59, 0, 0);
        add(1, 0, 0, 1, 0, 8'h00, 8'h58, 0, 1);
        add(0, 0, 0, 1, 0, 8'h00, 8'h58, 0, 1);
        add(1, 0, 0, 1, 0, 8'h00, 8'h58, 0, 1);
        add(1, 0, 0, 0, 0, 8'h00, 8'h58, 0, 0);
        add(0, 0, 0, 0, 1, 8'h45, 8'h45, 0, 0);
        add(1, 0, 0, 0, 1, 8'h7A, 8'h00, 0, 0);
        add(1, 0, 0, 0, 1, 8'h45, 8'h45, 0, 0);
        add(0, 0, 0, 0, 1, 8'h60, 8'h00, 0, 0);
        add(1, 1, 0, 0, 1, 8'h59, 8'h59, 0, 0);
        add(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 1, 0, 0, 8'h00, 8'h01, 0, 1);
        add(1, 1, 1, 1, 0, 8'h00, 8'h02, 0, 0);
        add(1, 0, 0, 1, 0, 8'h00, 8'h01, 0, 1);
        add(1, 0, 1, 0, 0, 8'h00, 8'h01, 0, 0);
        add(1, 0, 1, 0, 0, 8'h00, 8'h02, 0, 1);
        add(1, 0, 1, 0, 1, 8'h58, 8'h58, 0, 0);
        add(1, 0, 1, 0, 0, 8'h00, 8'h59, 0, 1);
        add(1, 0, 1, 0, 0, 8'h00, 8'h59, 0, 1);
        add(0, 0, 0, 0, 0, 8'h00, 8'h59, 0, 1);
        add(0, 0, 0, 0, 1, 8'h59, 8'h59, 0, 0);
        add(1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1);
        add(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ena, vecs[i].cin, vecs[i].up, vecs[i].down,
                  vecs[i].load, vecs[i].val);
            chk($sformatf("vec%0d_q", i), int'(q1), int'(vecs[i].exp_q));
            chk($sformatf("vec%0d_carry", i), int'(carry1), int'(vecs[i].exp_c));
            chk($sformatf("vec%0d_state", i), int'(st1), int'(vecs[i].exp_st));
        end

        // Both buttons held with cascade: cascade only, FSM stays idle
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, 1, 0, 8'h00);
            if (st1 != 2'd0) seen = 1'b1;
        end
        chk("both_btn_q", int'(q1), 'h20);
        chk("both_btn_idle", int'(seen), 0);

        // Modulus 24: preset, cascade wrap
        drive(0, 0, 0, 0, 1, 8'h23);
        chk("m24_load", int'(q2), 'h23);
        drive(1, 1, 0, 0, 0, 8'h00);
        chk("m24_wrap_q", int'(q2), 'h00);
        chk("m24_wrap_carry", int'(carry2), 1);
        drive(0, 0, 0, 0, 0, 8'h00);
        chk("m24_carry_drop", int'(carry2), 0);
        drive(0, 0, 0, 0, 1, 8'h24);
        chk("m24_load_range", int'(q2), 'h00);

        // Modulus 24: down wrap from 0 gives 23
        drive(1, 0, 0, 1, 0, 8'h00);
        chk("m24_down_wrap", int'(q2), 'h23);
        drive(0, 0, 0, 0, 1, 8'h00);

        // Modulus 24: async reset mid-repeat
        for (int t = 1; t <= 11; t++) drive(1, 0, 1, 0, 0, 8'h00);
        chk("m24_repeat_q", int'(q2), 'h03);
        chk("m24_repeat_state", int'(st2), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("m24_async_q", int'(q2), 'h00);
        chk("m24_async_state", int'(st2), 0);
        up = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 8'h00);
        chk("m24_post_reset_nostep", int'(q2), 'h00);
        drive(1, 0, 1, 0, 0, 8'h00);
        chk("m24_fresh_press", int'(q2), 'h01);
        chk("m24_fresh_state", int'(st2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised BCD modulo-N counter. It is the next generation of the clock's seconds/minutes/hours digit counters. It adds:
- configurable modulus and digit count
- cascade carry-in and carry-out
- synchronous preset load
- auto-repeat on the up/down set buttons
Instances are chained in the clock datapath (sec -> min -> hr) and feed the 7-segment display mux directly.

Parameters:
MODULUS, 60, count range 0..MODULUS-1; legal 2..10**DIGITS
DIGITS, 2, number of BCD digits; o_q width = 4*DIGITS
REPEAT_DELAY, 8, ticks a set button must be held before auto-repeat starts (>=1)
REPEAT_RATE, 2, ticks between auto-repeat steps once repeating (>=1)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_ena  in  1  one-cycle tick strobe; all counting and repeat timing advance only on cycles with i_ena=1
i_cin  in  1  cascade count-up request (carry from a lower stage), sampled on tick
i_up  in  1  set-button level, step up
i_down  in  1  set-button level, step down
i_load  in  1  synchronous preset strobe, independent of i_ena
i_load_val  in  4*DIGITS  BCD preset value
o_q  out  4*DIGITS  current count, BCD, digit 0 = LS nibble
o_carry  out  1  one-cycle pulse: cascade wrap MODULUS-1 -> 0

Behaviour:
- Reset (i_reset_n=0, async):
  - o_q=0, o_carry=0
  - repeat FSM to IDLE, tick counter=0
- Priority per clock edge:
  1. i_load: o_q<=i_load_val; FSM to IDLE; no carry.
  2. Else, only if i_ena=1: button handling, then cascade.
- Load validation:
  - If i_load_val has any nibble >9, or its value >=MODULUS, o_q<=0.
- Button/repeat FSM, evaluated on ticks only:
  - IDLE:
    - exactly one of i_up/i_down high: step once in that direction, clear tick counter, go DELAY.
  - DELAY:
    - same button still held: increment tick counter.
    - when the counter reaches REPEAT_DELAY: step, clear counter, go REPEAT.
  - REPEAT:
    - same button still held: every REPEAT_RATE ticks, step and clear counter.
  - Any state:
    - both buttons high, neither high, or the held direction changes: go IDLE with no step.
    - A direction change only starts a new press on the following tick from IDLE.
- Cascade:
  - On a tick where i_cin=1 and no button step occurs that tick: step up.
  - A button step takes precedence and i_cin is dropped; the set-mode user owns the counter.
- Step arithmetic, per-digit BCD with ripple:
  - Up from MODULUS-1 gives 0; down from 0 gives MODULUS-1.
  - Each digit stays within 0..9.
- o_carry:
  - Registered; high for exactly the one i_clk cycle after a cascade-driven up-wrap MODULUS-1 -> 0.
  - Button-driven wraps never assert o_carry, so setting minutes does not disturb hours.
- Load during held button:
  - Load wins; the FSM returns to IDLE.
  - The still-held button counts as a new press on the next tick.
- Reset asserted mid-repeat: everything clears immediately; no step on deassertion edge.
- i_ena held high continuously: every cycle is a tick; behaviour is identical, just faster.

Test Plan:
- Reset, then 59 ticks with i_cin=1 -> o_q=8'h59, o_carry=0. The 60th tick -> o_q=8'h00, and o_carry=1 for exactly one cycle on the following clock.
- i_up held for 1+8+2*3 ticks from 0 (defaults) -> steps on tick 1, 9, 11, 13, 15. o_q=8'h05. No o_carry.
- i_down pressed once from 0 -> o_q=8'h59, o_carry=0. Release, then press again -> o_q=8'h58.
- i_up=i_down=1 for 20 ticks with i_cin=1 -> o_q increments by 20 via cascade only; FSM stays IDLE.
- i_load with i_load_val=8'h45 -> o_q=8'h45 next cycle, regardless of i_ena. i_load_val=8'h7A and 8'h60 -> o_q=8'h00.
- MODULUS=24: preset 8'h23, one i_cin tick -> o_q=8'h00, o_carry pulse. Assert i_reset_n=0 asynchronously during i_up repeat -> o_q=0 immediately; no step on first tick after release without a fresh press edge.
